// File: rtl/qam_pkg.sv
// Shared types and helpers for the QAM mapper: state encoding, Gray decode,
// level computation and configuration legality check.
package qam_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Gray-to-binary over up to 8 bits; zero-extended inputs decode correctly
    function automatic logic [7:0] gray2bin(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Signed amplitude for one axis, wrapped to amp_w bits (two's complement)
    function automatic int qam_level(input logic [7:0] g, input int l,
                                     input int scale, input int amp_w);
        int k;
        int v;
        k = int'(gray2bin(g));
        v = (2 * k - (l - 1)) * scale;
        return (v <<< (32 - amp_w)) >>> (32 - amp_w);
    endfunction

    function automatic bit cfg_ok(input int bps, input int sps, input int scale,
                                  input int amp_w, input int depth);
        longint peak;
        longint lim;
        peak = ((longint'(1) << (bps / 2)) - 1) * longint'(scale);
        lim  = (longint'(1) << (amp_w - 1)) - 1;
        return (bps == 4 || bps == 6 || bps == 8)
            && (sps >= 2) && (sps <= 16)
            && (scale >= 1)
            && (amp_w >= 2) && (amp_w <= 32)
            && (peak <= lim)
            && (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/qam_sym_fifo.sv
// Small synchronous symbol FIFO with show-ahead read data, full/empty flags
// and an occupancy count. Pointer reset drops any stored contents.
module qam_sym_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a write into a full FIFO may proceed
    assign wr_ok = wr_en && (!full || rd_en);
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/qam_mapper.sv
// M-QAM Gray mapper and upsampler: queues symbol words, maps each half-word to
// a signed level and emits SPS samples per symbol with underrun reporting.
//
// state | meaning
// IDLE  | no symbol in flight; outputs invalid and zero
// RUN   | emitting samples of the current symbol, phase 0..SPS-1
module qam_mapper
    import qam_pkg::*;
#(
    parameter int BITS_PER_SYM = 4,
    parameter int SPS          = 4,
    parameter int AMP_W        = 18,
    parameter int SCALE        = 1024,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    axi_clk,
    input  logic                    axi_rstn,
    input  logic                    run,
    input  logic                    zero_stuff,
    input  logic                    din_valid,
    input  logic [BITS_PER_SYM-1:0] din,
    output logic                    din_ready,
    output logic                    dout_valid,
    output logic [AMP_W-1:0]        dout_i,
    output logic [AMP_W-1:0]        dout_q,
    output logic                    dout_sym_start,
    output logic                    underrun,
    output logic [15:0]             underrun_cnt
);

    localparam int HALF = BITS_PER_SYM / 2;
    localparam int L    = 1 << HALF;
    localparam int PH_W = $clog2(SPS);
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;

    if (!cfg_ok(BITS_PER_SYM, SPS, SCALE, AMP_W, FIFO_DEPTH)) begin : g_bad_cfg
        $error("qam_mapper: illegal BITS_PER_SYM/SPS/SCALE/AMP_W/FIFO_DEPTH combination");
    end

    state_t                  state;
    logic [PH_W-1:0]         phase;
    logic [AMP_W-1:0]        lvl_i;
    logic [AMP_W-1:0]        lvl_q;
    logic [AMP_W-1:0]        map_i;
    logic [AMP_W-1:0]        map_q;
    logic                    starve;
    logic                    rdy_en;
    logic                    last;
    logic                    pop;
    logic                    wr_en;

    logic [BITS_PER_SYM-1:0] fifo_rd_data;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_count;
    logic                    unused_fifo_count;

    // Occupancy is only of interest to observers; the sequencer uses the flags
    assign unused_fifo_count = ^fifo_count;

    // Held low through reset, ready from the first edge after release
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    assign din_ready = rdy_en && !fifo_full;
    assign wr_en     = din_valid && din_ready;
    assign last      = (phase == PH_W'(SPS - 1));
    assign pop       = run && !fifo_empty && ((state == IDLE) || last);

    assign map_i = AMP_W'(qam_level(8'(fifo_rd_data[BITS_PER_SYM-1:HALF]), L, SCALE, AMP_W));
    assign map_q = AMP_W'(qam_level(8'(fifo_rd_data[HALF-1:0]), L, SCALE, AMP_W));

    qam_sym_fifo #(
        .WIDTH (BITS_PER_SYM),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (axi_clk),
        .rst_n   (axi_rstn),
        .wr_en   (wr_en),
        .wr_data (din),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state          <= IDLE;
            phase          <= '0;
            lvl_i          <= '0;
            lvl_q          <= '0;
            starve         <= 1'b0;
            dout_valid     <= 1'b0;
            dout_i         <= '0;
            dout_q         <= '0;
            dout_sym_start <= 1'b0;
            underrun       <= 1'b0;
            underrun_cnt   <= '0;
        end else begin
            dout_valid     <= 1'b0;
            dout_sym_start <= 1'b0;
            dout_i         <= '0;
            dout_q         <= '0;
            starve         <= 1'b0;
            // Starvation is flagged alongside the last sample and reported one cycle later
            underrun       <= starve;
            if (starve && (underrun_cnt != 16'hFFFF)) begin
                underrun_cnt <= underrun_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        lvl_i <= map_i;
                        lvl_q <= map_q;
                        phase <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    dout_valid     <= 1'b1;
                    dout_sym_start <= (phase == '0);
                    if ((phase == '0) || !zero_stuff) begin
                        dout_i <= lvl_i;
                        dout_q <= lvl_q;
                    end
                    if (last) begin
                        if (pop) begin
                            lvl_i <= map_i;
                            lvl_q <= map_q;
                            phase <= '0;
                        end else begin
                            // run low is a graceful stop, not a starvation
                            state  <= IDLE;
                            starve <= run;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
